// File: rtl/audio_sram_sample_streamer_if.sv
// rtl/audio_sram_sample_streamer_if.sv - SRAM read port plus stereo sample stream bundle
interface audio_sram_sample_streamer_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] sram_address;
  logic              sram_chipselect;
  logic              sram_write;
  logic [3:0]        sram_byteenable;
  logic              sram_clken;
  logic [31:0]       sram_readdata;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_left;
  logic [15:0]       out_right;

  modport master (
    output sram_address, sram_chipselect, sram_write, sram_byteenable, sram_clken,
    input  sram_readdata,
    output out_valid, out_left, out_right,
    input  out_ready
  );

  modport slave (
    input  sram_address, sram_chipselect, sram_write, sram_byteenable, sram_clken,
    output sram_readdata,
    input  out_valid, out_left, out_right,
    output out_ready
  );
endinterface

// File: rtl/audio_sram_sample_streamer.sv
// rtl/audio_sram_sample_streamer.sv - fetches a word range from the audio SRAM into a
// small prefetch FIFO and presents each word as one stereo sample on a valid/ready stream
module audio_sram_sample_streamer #(
  parameter int ADDR_W     = 17,
  parameter int MEM_WORDS  = 80000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic                         loop_en_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [ADDR_W-1:0]            num_words_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [15:0]                  underrun_cnt_o,
  audio_sram_sample_streamer_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic              loop_q, loop_d;
  logic              inflight_q, inflight_d;
  logic              zero_done_q, zero_done_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       underrun_q, underrun_d;
  logic [31:0]       fifo_mem [FIFO_DEPTH];

  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              credit_ok;
  logic [OCC_W-1:0]  occupancy;
  logic [ADDR_W-1:0] addr_inc;
  logic [31:0]       head;

  assign fifo_empty = (count_q == '0);
  assign push       = inflight_q & ~stop_i;
  assign pop        = ~fifo_empty & bus.out_ready;
  // Credit includes the pop happening this cycle so a 2-deep FIFO sustains one sample per cycle.
  assign occupancy  = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign credit_ok  = (occupancy < OCC_W'(FIFO_DEPTH));
  assign addr_inc   = (addr_q == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    loop_d      = loop_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    zero_done_d = 1'b0;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (num_words_i != '0) begin
            state_d     = ST_FETCH;
            base_d      = base_addr_i;
            len_d       = num_words_i;
            loop_d      = loop_en_i;
            addr_d      = base_addr_i;
            remaining_d = num_words_i;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (credit_ok) begin
          issue       = 1'b1;
          addr_d      = addr_inc;
          remaining_d = remaining_q - ADDR_W'(1);
          if (remaining_q == ADDR_W'(1)) begin
            if (loop_q) begin
              addr_d      = base_q;
              remaining_d = len_q;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (stop_i) begin
      state_d     = ST_IDLE;
      issue       = 1'b0;
      zero_done_d = 1'b0;
    end

    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    if (stop_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    underrun_d = underrun_q;
    if (state_q == ST_FETCH && bus.out_ready && fifo_empty && underrun_q != 16'hFFFF)
      underrun_d = underrun_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      zero_done_q <= zero_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underrun_q  <= underrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.sram_readdata;
  end

  assign bus.sram_address    = issue ? addr_q : '0;
  assign bus.sram_chipselect = issue;
  assign bus.sram_write      = 1'b0;
  assign bus.sram_byteenable = 4'hF;
  assign bus.sram_clken      = 1'b1;
  assign bus.out_valid       = ~fifo_empty;
  assign bus.out_left        = fifo_empty ? 16'h0 : head[31:16];
  assign bus.out_right       = fifo_empty ? 16'h0 : head[15:0];

  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = zero_done_q |
                          (state_q == ST_DRAIN && !inflight_q && fifo_empty && !stop_i);
  assign underrun_cnt_o = underrun_q;
endmodule

// File: tb/tb_audio_sram_sample_streamer.sv
// tb/tb_audio_sram_sample_streamer.sv - scoreboard bench for the audio SRAM sample streamer
module tb_audio_sram_sample_streamer;
  localparam int ADDR_W    = 17;
  localparam int MEM_WORDS = 80000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              start1, stop1, loop1, busy1, done1;
  logic [ADDR_W-1:0] base1, len1;
  logic [15:0]       urun1;
  logic              start2, stop2, loop2, busy2, done2;
  logic [ADDR_W-1:0] base2, len2;
  logic [15:0]       urun2;

  audio_sram_sample_streamer_if #(.ADDR_W(ADDR_W)) bus1 ();
  audio_sram_sample_streamer_if #(.ADDR_W(ADDR_W)) bus2 ();

  audio_sram_sample_streamer #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start1), .stop_i(stop1), .loop_en_i(loop1),
    .base_addr_i(base1), .num_words_i(len1), .busy_o(busy1), .done_o(done1),
    .underrun_cnt_o(urun1), .bus(bus1)
  );

  audio_sram_sample_streamer #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(2)) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start2), .stop_i(stop2), .loop_en_i(loop2),
    .base_addr_i(base2), .num_words_i(len2), .busy_o(busy2), .done_o(done2),
    .underrun_cnt_o(urun2), .bus(bus2)
  );

  // SRAM models: word at address i holds 0x00010002 + i, returned one cycle after chipselect
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus1.sram_readdata <= 32'h0;
    else if (bus1.sram_chipselect) bus1.sram_readdata <= 32'h00010002 + 32'(bus1.sram_address);
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus2.sram_readdata <= 32'h0;
    else if (bus2.sram_chipselect) bus2.sram_readdata <= 32'h00010002 + 32'(bus2.sram_address);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0]       obs1[$], obs2[$];
  logic [ADDR_W-1:0] addr1[$], addr2[$];
  int                pop_cyc1[$], pop_cyc2[$], done_q1[$];

  always @(negedge clk) begin
    if (bus1.out_valid && bus1.out_ready) begin
      obs1.push_back({bus1.out_left, bus1.out_right});
      pop_cyc1.push_back(cyc);
    end
    if (bus1.sram_chipselect) addr1.push_back(bus1.sram_address);
    if (done1) done_q1.push_back(cyc);
    if (bus2.out_valid && bus2.out_ready) begin
      obs2.push_back({bus2.out_left, bus2.out_right});
      pop_cyc2.push_back(cyc);
    end
    if (bus2.sram_chipselect) addr2.push_back(bus2.sram_address);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start1(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                              input logic lp);
    base1 = b; len1 = l; loop1 = lp; start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic wait_done1(input int d0, input int budget, output bit ok);
    int n = 0;
    while (done_q1.size() == d0 && n < budget) begin
      tick();
      n++;
    end
    ok = (done_q1.size() > d0);
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start1 = 0; stop1 = 0; loop1 = 0; base1 = '0; len1 = '0;
    start2 = 0; stop2 = 0; loop2 = 0; base2 = '0; len2 = '0;
    bus1.out_ready = 1'b0; bus2.out_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done1); end
    n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus1.out_valid); end
    n_checks++; if (bus1.sram_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b expected 0", bus1.sram_chipselect); end
    n_checks++; if (bus1.sram_address !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus1.sram_address); end
    n_checks++; if (bus1.sram_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", bus1.sram_write); end
    n_checks++; if (bus1.sram_byteenable !== 4'hF) begin n_fail++; $display("FAIL reset_be: got %h expected f", bus1.sram_byteenable); end
    n_checks++; if (bus1.sram_clken !== 1'b1) begin n_fail++; $display("FAIL reset_clken: got %b expected 1", bus1.sram_clken); end
    n_checks++; if ({bus1.out_left, bus1.out_right} !== 32'h0) begin n_fail++; $display("FAIL reset_sample: got %h expected 0", {bus1.out_left, bus1.out_right}); end
    n_checks++; if (urun1 !== 16'h0 || urun2 !== 16'h0) begin n_fail++; $display("FAIL reset_underrun: got %h/%h expected 0/0", urun1, urun2); end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic_playback();
    logic [31:0] exp_q[$];
    int o0 = obs1.size(), a0 = addr1.size(), d0 = done_q1.size();
    int c0, lat = -1, nobs, nadr;
    bit ok;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h00010002 + 32'(10 + i));
    bus1.out_ready = 1'b1;
    c0 = cyc;
    pulse_start1(17'd10, 17'd4, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (bus1.out_valid) begin lat = cyc - c0; break; end
      tick();
    end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    wait_done1(d0, 50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got none expected done"); end
    nobs = obs1.size() - o0;
    nadr = addr1.size() - a0;
    n_checks++; if (nobs != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", nobs); end
    for (int i = 0; i < 4 && i < nobs; i++) begin
      logic [31:0] e = exp_q.pop_front();
      n_checks++; if (obs1[o0+i] !== e) begin n_fail++; $display("FAIL basic_sample[%0d]: got %h expected %h", i, obs1[o0+i], e); end
    end
    for (int i = 0; i < 4 && i < nadr; i++) begin
      n_checks++; if (addr1[a0+i] !== ADDR_W'(10 + i)) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, addr1[a0+i], 10 + i); end
    end
    n_checks++; if (done_q1.size() - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_q1.size() - d0); end
    if (ok && pop_cyc1.size() > 0) begin
      n_checks++; if (done_q1[d0] != pop_cyc1[$] + 1) begin n_fail++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_q1[d0], pop_cyc1[$] + 1); end
    end
  endtask

  task automatic test_backpressure();
    int o0 = obs1.size(), a0 = addr1.size(), d0 = done_q1.size();
    logic [31:0] first_head = 32'h0;
    int changes = 0, nobs;
    bit seen = 0, ok;
    bus1.out_ready = 1'b0;
    pulse_start1(17'd20, 17'd8, 1'b0);
    repeat (20) begin
      tick();
      if (bus1.out_valid) begin
        if (!seen) begin first_head = {bus1.out_left, bus1.out_right}; seen = 1; end
        else if ({bus1.out_left, bus1.out_right} !== first_head) changes++;
      end
    end
    n_checks++; if (addr1.size() - a0 != 4) begin n_fail++; $display("FAIL bp_reads: got %0d expected 4", addr1.size() - a0); end
    n_checks++; if (bus1.sram_chipselect !== 1'b0) begin n_fail++; $display("FAIL bp_cs: got %b expected 0", bus1.sram_chipselect); end
    n_checks++; if (first_head !== 32'h00010016) begin n_fail++; $display("FAIL bp_head: got %h expected 00010016", first_head); end
    n_checks++; if (changes != 0) begin n_fail++; $display("FAIL bp_head_stable: got %0d changes expected 0", changes); end
    bus1.out_ready = 1'b1;
    wait_done1(d0, 60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout: got none expected done"); end
    nobs = obs1.size() - o0;
    n_checks++; if (nobs != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", nobs); end
    for (int i = 0; i < 8 && i < nobs; i++) begin
      n_checks++; if (obs1[o0+i] !== 32'h00010002 + 32'(20 + i)) begin n_fail++; $display("FAIL bp_sample[%0d]: got %h expected %h", i, obs1[o0+i], 32'h00010002 + 32'(20 + i)); end
    end
  endtask

  task automatic test_loop_and_stop();
    int o0 = obs1.size(), a0 = addr1.size(), d0 = done_q1.size();
    int bad_addr = 0, bad_smp = 0, nadr, nobs, o1, a1;
    logic [31:0] exp_q[$];
    bus1.out_ready = 1'b1;
    pulse_start1(17'd5, 17'd3, 1'b1);
    repeat (25) tick();
    stop1 = 1'b1;
    tick();
    stop1 = 1'b0;
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL loop_stop_busy: got %b expected 0", busy1); end
    n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL loop_stop_valid: got %b expected 0", bus1.out_valid); end
    o1 = obs1.size(); a1 = addr1.size();
    repeat (5) tick();
    n_checks++; if (obs1.size() != o1 || addr1.size() != a1) begin n_fail++; $display("FAIL loop_after_stop: got %0d samples %0d reads expected none", obs1.size() - o1, addr1.size() - a1); end
    nadr = a1 - a0;
    nobs = o1 - o0;
    for (int i = 0; i < nobs; i++) exp_q.push_back(32'h00010002 + 32'(5 + i % 3));
    for (int i = 0; i < nadr; i++) if (addr1[a0+i] !== ADDR_W'(5 + i % 3)) bad_addr++;
    for (int i = 0; i < nobs; i++) if (obs1[o0+i] !== exp_q.pop_front()) bad_smp++;
    n_checks++; if (nadr < 20) begin n_fail++; $display("FAIL loop_reads: got %0d expected >=20", nadr); end
    n_checks++; if (bad_addr != 0) begin n_fail++; $display("FAIL loop_addr_seq: got %0d bad expected 0", bad_addr); end
    n_checks++; if (bad_smp != 0 || nobs < 18) begin n_fail++; $display("FAIL loop_samples: got %0d bad of %0d expected 0 of >=18", bad_smp, nobs); end
    n_checks++; if (done_q1.size() != d0) begin n_fail++; $display("FAIL loop_no_done: got %0d expected 0", done_q1.size() - d0); end
  endtask

  task automatic test_wrap();
    int o0 = obs1.size(), a0 = addr1.size(), d0 = done_q1.size();
    int a = 79998, nobs, nadr;
    int exp_a[$];
    bit ok;
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(a);
      a = (a == MEM_WORDS - 1) ? 0 : a + 1;
    end
    bus1.out_ready = 1'b1;
    pulse_start1(17'd79998, 17'd4, 1'b0);
    wait_done1(d0, 50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_done_timeout: got none expected done"); end
    nobs = obs1.size() - o0;
    nadr = addr1.size() - a0;
    n_checks++; if (nobs != 4 || nadr != 4) begin n_fail++; $display("FAIL wrap_count: got %0d/%0d expected 4/4", nobs, nadr); end
    for (int i = 0; i < 4 && i < nadr && i < nobs; i++) begin
      n_checks++; if (addr1[a0+i] !== ADDR_W'(exp_a[i])) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, addr1[a0+i], exp_a[i]); end
      n_checks++; if (obs1[o0+i] !== 32'h00010002 + 32'(exp_a[i])) begin n_fail++; $display("FAIL wrap_sample[%0d]: got %h expected %h", i, obs1[o0+i], 32'h00010002 + 32'(exp_a[i])); end
    end
  endtask

  task automatic test_zero_len();
    int a0 = addr1.size(), d0 = done_q1.size(), c0 = cyc;
    bit busy_seen = 0;
    pulse_start1(17'd3, 17'd0, 1'b0);
    repeat (5) begin
      if (busy1) busy_seen = 1;
      tick();
    end
    n_checks++; if (busy_seen) begin n_fail++; $display("FAIL zero_busy: got 1 expected 0"); end
    n_checks++; if (done_q1.size() - d0 != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d expected 1", done_q1.size() - d0); end
    else begin
      n_checks++; if (done_q1[d0] != c0 + 1) begin n_fail++; $display("FAIL zero_done_timing: got cycle %0d expected %0d", done_q1[d0], c0 + 1); end
    end
    n_checks++; if (addr1.size() != a0) begin n_fail++; $display("FAIL zero_reads: got %0d expected 0", addr1.size() - a0); end
  endtask

  task automatic test_start_with_stop();
    int a0 = addr1.size(), d0 = done_q1.size();
    bit busy_seen = 0;
    stop1 = 1'b1;
    pulse_start1(17'd40, 17'd4, 1'b0);
    stop1 = 1'b0;
    repeat (5) begin
      if (busy1) busy_seen = 1;
      tick();
    end
    n_checks++; if (busy_seen || addr1.size() != a0 || done_q1.size() != d0) begin n_fail++; $display("FAIL start_stop: got busy=%b reads=%0d dones=%0d expected 0/0/0", busy_seen, addr1.size() - a0, done_q1.size() - d0); end
  endtask

  task automatic test_underrun_depth2();
    int o0 = obs2.size(), p0 = pop_cyc2.size(), nobs, gaps = 0, bad = 0;
    bus2.out_ready = 1'b1;
    base2 = 17'd0; len2 = 17'd5; loop2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (30) tick();
    n_checks++; if (urun2 !== 16'd2) begin n_fail++; $display("FAIL underrun_startup: got %0d expected 2", urun2); end
    nobs = obs2.size() - o0;
    for (int i = 1; i < nobs; i++) if (pop_cyc2[p0+i] != pop_cyc2[p0+i-1] + 1) gaps++;
    for (int i = 0; i < nobs; i++) if (obs2[o0+i] !== 32'h00010002 + 32'(i % 5)) bad++;
    n_checks++; if (gaps != 0 || nobs < 25) begin n_fail++; $display("FAIL d2_throughput: got %0d gaps in %0d samples expected 0 in >=25", gaps, nobs); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL d2_samples: got %0d bad expected 0", bad); end
    stop2 = 1'b1;
    tick();
    stop2 = 1'b0;
    repeat (5) tick();
    n_checks++; if (urun2 !== 16'd2 || busy2 !== 1'b0) begin n_fail++; $display("FAIL underrun_hold: got %0d busy=%b expected 2 busy=0", urun2, busy2); end
  endtask

  task automatic test_reset_mid_fetch();
    bus1.out_ready = 1'b0;
    pulse_start1(17'd30, 17'd10, 1'b0);
    repeat (3) tick();
    n_checks++; if (busy1 !== 1'b1 || bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got busy=%b valid=%b expected 1/1", busy1, bus1.out_valid); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy1 !== 1'b0 || bus1.out_valid !== 1'b0 || bus1.sram_chipselect !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got busy=%b valid=%b cs=%b expected 0/0/0", busy1, bus1.out_valid, bus1.sram_chipselect); end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus1.out_valid !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL midreset_release: got valid=%b busy=%b expected 0/0", bus1.out_valid, busy1); end
  endtask

  initial begin
    test_reset();
    test_basic_playback();
    test_backpressure();
    test_loop_and_stop();
    test_wrap();
    test_zero_len();
    test_start_with_stop();
    test_underrun_depth2();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
